// File: rtl/hm_cdc_rx.sv
// Receive-side synchroniser for the hm core. It turns asynchronous event lines into
// counted sys_clk pulses and accepts the asynchronous status bus only after it has held stable.
module hm_cdc_rx #(
  parameter int N_PULSE      = 6,
  parameter int STAGES       = 2,
  parameter int BUS_W        = 32,
  parameter int STABLE       = 2,
  parameter int UNSTABLE_LIM = 64,
  parameter int CNT_W        = 16,
  localparam int SEL_W       = (N_PULSE > 1) ? $clog2(N_PULSE) : 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [N_PULSE-1:0] async_evt,
  input  logic [N_PULSE-1:0] evt_mode,
  output logic [N_PULSE-1:0] level_o,
  output logic [N_PULSE-1:0] pulse_o,
  input  logic               cnt_clr,
  input  logic [SEL_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]   cnt_o,
  input  logic [BUS_W-1:0]   async_bus,
  output logic [BUS_W-1:0]   bus_o,
  output logic               bus_upd,
  output logic               bus_stale
);

  localparam int PRIME_N = STAGES + 1;
  localparam int PRIME_W = $clog2(PRIME_N + 1);
  localparam int STAB_W  = $clog2(STABLE + 1);
  localparam int UNST_W  = $clog2(UNSTABLE_LIM + 1);

  logic [N_PULSE-1:0] evt_sync [STAGES];
  logic [N_PULSE-1:0] evt_prev;
  logic [N_PULSE-1:0] evt_edge;
  logic [N_PULSE-1:0] edge_q;
  logic [PRIME_W-1:0] prime_cnt;
  logic               primed;
  logic [CNT_W-1:0]   cnt [N_PULSE];

  logic [BUS_W-1:0]   bus_sync [STAGES];
  logic [BUS_W-1:0]   bus_last;
  logic               bus_chg;
  logic               bus_steady;
  logic [STAB_W-1:0]  stab_cnt;
  logic [UNST_W-1:0]  unst_cnt;

  // ---------------------------------------------------------------------------
  // Event path
  // ---------------------------------------------------------------------------
  assign level_o = evt_sync[STAGES-1];
  assign primed  = (prime_cnt == PRIME_W'(PRIME_N));

  // NOTE: always_comb outputs get a value on every path, so no latch can be inferred.
  always_comb begin
    evt_edge = '0;
    evt_edge = (evt_mode & (level_o ^ evt_prev)) | (~evt_mode & level_o & ~evt_prev);
  end

  // Edges are masked until the chain holds post-reset samples, so lines already high
  // at release do not look like events.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < STAGES; i++) evt_sync[i] <= '0;
      evt_prev  <= '0;
      edge_q    <= '0;
      pulse_o   <= '0;
      prime_cnt <= '0;
    end else begin
      evt_sync[0] <= async_evt;
      for (int i = 1; i < STAGES; i++) evt_sync[i] <= evt_sync[i-1];
      evt_prev <= level_o;
      edge_q   <= primed ? evt_edge : '0;
      pulse_o  <= edge_q;
      if (!primed) prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Event counters and readout
  // ---------------------------------------------------------------------------
  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_PULSE; i++) cnt[i] <= '0;
      cnt_o <= '0;
    end else begin
      for (int i = 0; i < N_PULSE; i++) begin
        if (cnt_clr)
          cnt[i] <= pulse_o[i] ? CNT_W'(1) : '0;
        else if (pulse_o[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
      cnt_o <= (32'(cnt_sel) < N_PULSE) ? cnt[cnt_sel] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Status bus path
  // ---------------------------------------------------------------------------
  // stab_cnt is the run length of the value at the chain output, counting its first
  // appearance as sample one, so acceptance lands STAGES+STABLE-1 edges after capture.
  assign bus_last   = bus_sync[STAGES-1];
  assign bus_chg    = (bus_sync[STAGES-2] != bus_last);
  assign bus_steady = (stab_cnt == STAB_W'(STABLE));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < STAGES; i++) bus_sync[i] <= '0;
      stab_cnt  <= '0;
      unst_cnt  <= '0;
      bus_o     <= '0;
      bus_upd   <= 1'b0;
      bus_stale <= 1'b0;
    end else begin
      bus_sync[0] <= async_bus;
      for (int i = 1; i < STAGES; i++) bus_sync[i] <= bus_sync[i-1];

      if (bus_chg)          stab_cnt <= STAB_W'(1);
      else if (!bus_steady) stab_cnt <= stab_cnt + STAB_W'(1);

      bus_upd <= 1'b0;
      if (bus_steady && (bus_last != bus_o)) begin
        bus_o   <= bus_last;
        bus_upd <= 1'b1;
      end

      if (bus_steady) begin
        unst_cnt  <= '0;
        bus_stale <= 1'b0;
      end else begin
        if (unst_cnt != UNST_W'(UNSTABLE_LIM)) unst_cnt <= unst_cnt + UNST_W'(1);
        if (unst_cnt == UNST_W'(UNSTABLE_LIM)) bus_stale <= 1'b1;
      end
    end
  end

endmodule
